uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Synchronous UART receive front-end for the serial console input of the RISC-V SoC. Sits directly upstream of the core's UART monitor/loader: it takes the raw, asynchronous `rx` pin from the chip pads, synchronises and deframes 8N1 characters, and presents received bytes through a 4-entry FIFO with a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit. 50 MHz / 115200 baud. Legal range 4..65535.
- `DIV_W`, default 16: width of the bit-period counter. Must satisfy `CLK_DIV-1 < 2^DIV_W`.
- `clk`  in  1  system clock; the single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  byte at the FIFO head. Valid only while `rx_valid` is high.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts the head byte. A pop occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a received byte was dropped because the FIFO was full.

## Operation
- **Synchroniser:** `rx` passes through two flops to produce `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Bit counter:** `cnt` is DIV_W bits wide and counts down. `bitn` is a 3-bit data-bit index.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** when `rx_s == 0`, go to START and load `cnt = CLK_DIV/2 - 1` (integer floor).
- **START:** when `cnt == 0`, sample `rx_s`.
  - `rx_s == 1` is a false start: return to IDLE. No flag is raised.
  - `rx_s == 0`: go to DATA with `cnt = CLK_DIV-1` and `bitn = 0`.
- **DATA:** when `cnt == 0`, shift `rx_s` into the MSB of the shift register (bits arrive LSB first) and reload `cnt = CLK_DIV-1`.
  - If `bitn == 7`, go to STOP; otherwise increment `bitn`.
- **STOP:** when `cnt == 0`, sample `rx_s`.
  - `rx_s == 1`: push the shift register into the FIFO and go to IDLE.
  - `rx_s == 0`: assert `frame_err` for one cycle, discard the byte and go to BREAK.
- **BREAK:** stay here until `rx_s == 1`, then go to IDLE. A held-low line therefore produces exactly one `frame_err`.
- **FIFO:** depth 4, with 2-bit read/write pointers and a 3-bit count. Pointers wrap modulo 4.
  - A push when count is 4 and no pop happens in the same cycle: the byte is dropped and `overrun` pulses.
  - A push and a pop in the same cycle are both performed and count is unchanged. This holds at count 4 as well, and no overrun is raised.
  - A pop when the FIFO is empty is ignored.
  - `rx_data` is `mem[rd_ptr]`, driven combinationally from registered storage.
- **Reset** (at any time, including mid-frame):
  - state IDLE, counters 0, pointers and count 0, shift register 0;
  - `rx_valid = 0`, `rx_data = 0x00`, `frame_err = 0`, `overrun = 0`;
  - synchroniser flops set to 1;
  - a partially received frame is abandoned.

## Timing
- **t0** is the first cycle with `rx_s == 0` in IDLE. This is 2–3 cycles after the pad edge, depending on synchroniser latency.
- **Sample points:**
  - start-bit centre check at t0 + `CLK_DIV/2`;
  - data bit i sampled at t0 + `CLK_DIV/2` + (i+1)·`CLK_DIV`;
  - stop bit sampled at t0 + `CLK_DIV/2` + 9·`CLK_DIV`.
- **Push timing:** the FIFO write takes effect at the clock edge that ends the stop-sample cycle. `rx_valid` is high from the next cycle. `frame_err` and `overrun` are high in that same next cycle, for one cycle.
- **Back-to-back frames:** IDLE is re-entered immediately after the stop sample. A start bit that directly follows the stop bit, with zero idle time, is accepted.
- **Pop timing:** takes effect at the clock edge where `rx_valid && rx_ready`. The next head byte, or `rx_valid = 0`, is visible in the following cycle.
- **Throughput:** one byte per 10·`CLK_DIV` cycles. There is no combinational path from `rx_ready` to `rx_valid`.

## Test plan
- **Reset values:** with `CLK_DIV = 8`, hold `rst` for 2 cycles with `rx = 1` → `rx_valid = 0`, `rx_data = 0x00`, `frame_err = 0`, `overrun = 0`.
- **Single byte:** `CLK_DIV = 8`, send 0xA5 (8N1) with `rx_ready = 0` → `rx_valid` rises exactly 1 cycle after the stop sample and `rx_data = 0xA5`. Then assert `rx_ready` for 1 cycle → `rx_valid = 0` on the next cycle.
- **Glitch rejection:** drive `rx` low for 3 cycles, then high → no state change past START, `rx_valid` stays 0, no `frame_err`.
- **Framing error:** send 0x3C with the stop bit low, holding the line low for 40 cycles → exactly one `frame_err` pulse and no push. A following 0x5A is then received correctly.
- **Overrun and simultaneous push/pop:** send 0x01..0x05 back-to-back with `rx_ready = 0` → FIFO holds 0x01..0x04 and `overrun` pulses once (0x05 dropped). Repeat, but assert `rx_ready` in the cycle the fifth push lands → no overrun, and bytes 0x02..0x05 drain in order.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF, then send 0x81 → only 0x81 is received, with no `frame_err`.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the console UART: serial pad input plus the byte
// stream handshake and error pulses presented to the consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  rx,
    input  rx_ready,
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output rx,
    output rx_ready,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling deframer and a
// 4-entry byte FIFO with valid/ready pop and single-cycle error pulses.
module uart_rx_deframer #(
  parameter int CLK_DIV = 434,
  parameter int DIV_W   = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] CNT_FULL = DIV_W'(CLK_DIV - 1);

  logic             rx_p0;
  logic             rx_s;
  logic [2:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [2:0]       bitn;
  logic [7:0]       shreg;
  logic [7:0]       mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             frame_err_q;
  logic             overrun_q;
  logic             tick;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  assign tick  = (cnt == '0);
  assign push  = (state == S_STOP) && tick && rx_s;
  assign pop   = bus.rx_ready && (count != 3'd0);
  assign full  = (count == 3'd4);
  // A full FIFO still accepts the new byte when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  // Stage p0 -> rx_s: metastability guard on the pad input
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= bus.rx;
      rx_s  <= rx_p0;
    end
  end

  // Deframer: cnt runs down to the next sample point of the current bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= CNT_HALF;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              cnt   <= CNT_FULL;
              bitn  <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= CNT_FULL;
            if (bitn == 3'd7) state <= S_STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tick) state <= rx_s ? S_IDLE : S_BREAK;
          else      cnt   <= cnt - 1'b1;
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO and error pulses, all updated on the edge ending the stop sample
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      frame_err_q <= (state == S_STOP) && tick && !rx_s;
      overrun_q   <= push && full && !pop;
      if (wr_en) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({wr_en, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.rx_data   = mem[rd_ptr];
  assign bus.rx_valid  = (count != 3'd0);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frame-level event model with a queue FIFO,
// directed scenarios plus randomized traffic with random consumer stalls.
module tb_uart_rx_deframer;
  localparam int DIV = 8;
  // pad edge -> two sync flops -> half bit -> 9 bit periods -> push edge
  localparam int PUSH_LAT = 2 + DIV / 2 + 9 * DIV + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_rx_if bus ();

  uart_rx_deframer #(.CLK_DIV(DIV), .DIV_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int         c;
    bit         ferr;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  logic [7:0] mq[$];
  logic [7:0] drained[$];
  bit         pop_prev = 1'b0;
  bit         rst_prev = 1'b1;
  int         fe_seen  = 0;
  int         ov_seen  = 0;
  bit         m_push, m_ferr, m_ov, m_full;
  logic [7:0] m_pb;
  ev_t        m_e;

  // Reference: frame completions land at known cycles; FIFO is a plain queue.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_prev) begin
        mq.delete();
        evq.delete();
        check("rst_valid", bus.rx_valid, 0);
        check("rst_data", bus.rx_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
      end else begin
        m_push = 1'b0; m_ferr = 1'b0; m_ov = 1'b0; m_pb = 8'h00;
        while (evq.size() > 0 && evq[0].c <= cyc) begin
          m_e = evq.pop_front();
          if (m_e.c == cyc) begin
            if (m_e.ferr) m_ferr = 1'b1;
            else begin m_push = 1'b1; m_pb = m_e.b; end
          end
        end
        m_full = (mq.size() == 4);
        if (pop_prev) void'(mq.pop_front());
        if (m_push) begin
          if (m_full && !pop_prev) m_ov = 1'b1;
          else mq.push_back(m_pb);
        end
        check("rx_valid", bus.rx_valid, (mq.size() > 0) ? 1 : 0);
        if (mq.size() > 0) check("rx_data", bus.rx_data, mq[0]);
        check("frame_err", bus.frame_err, m_ferr);
        check("overrun", bus.overrun, m_ov);
      end
      if (bus.frame_err === 1'b1) fe_seen++;
      if (bus.overrun === 1'b1) ov_seen++;
    end
    pop_prev = (mq.size() > 0) && (bus.rx_ready === 1'b1);
    rst_prev = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 2000) begin
      step();
      g++;
    end
    check("wait_reached", cyc, t);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.c = cyc + PUSH_LAT;
    e.ferr = !stop_ok;
    e.b = b;
    evq.push_back(e);
    bus.rx = 1'b0;
    repeat (DIV) step();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (DIV) step();
    end
    bus.rx = stop_ok;
    repeat (DIV) step();
  endtask

  task automatic drain();
    drained.delete();
    for (int i = 0; i < 16 && bus.rx_valid === 1'b1; i++) begin
      drained.push_back(bus.rx_data);
      bus.rx_ready = 1'b1;
      step();
    end
    bus.rx_ready = 1'b0;
    check("drained_empty", bus.rx_valid, 0);
  endtask

  bit rnd_on = 1'b0;
  int rdy_thresh = 0;

  initial begin
    #(900000);
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, fe0, ov0, b, ok;
    bus.rx = 1'b1;
    bus.rx_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    check("reset_valid", bus.rx_valid, 0);
    check("reset_data", bus.rx_data, 8'h00);
    check("reset_frame_err", bus.frame_err, 0);
    check("reset_overrun", bus.overrun, 0);
    rst = 1'b0;
    repeat (5) step();

    // Single byte with exact arrival timing, then a one-cycle pop
    k = cyc;
    fork
      send(8'hA5, 1'b1);
      begin
        wait_until(k + 78);
        check("a5_valid_before", bus.rx_valid, 0);
        step();
        check("a5_valid_at", bus.rx_valid, 1);
        check("a5_data", bus.rx_data, 8'hA5);
      end
    join
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    check("a5_popped", bus.rx_valid, 0);

    // Short low glitch is a false start
    fe0 = fe_seen;
    bus.rx = 1'b0;
    repeat (3) step();
    bus.rx = 1'b1;
    repeat (20) step();
    check("glitch_valid", bus.rx_valid, 0);
    check("glitch_ferr", fe_seen - fe0, 0);

    // Stop bit low, line held low: one frame_err, then recovery
    fe0 = fe_seen;
    send(8'h3C, 1'b0);
    repeat (32) step();
    bus.rx = 1'b1;
    repeat (5) step();
    check("ferr_count", fe_seen - fe0, 1);
    check("ferr_no_push", bus.rx_valid, 0);
    send(8'h5A, 1'b1);
    drain();
    check("after_ferr_n", drained.size(), 1);
    if (drained.size() == 1) check("after_ferr_byte", drained[0], 8'h5A);

    // Overrun: fifth byte dropped
    ov0 = ov_seen;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    repeat (4) step();
    check("overrun_count", ov_seen - ov0, 1);
    drain();
    check("overrun_n", drained.size(), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++) check("overrun_byte", drained[i], i + 1);

    // Push and pop on the same edge while full
    ov0 = ov_seen;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    k = cyc;
    fork
      send(8'h05, 1'b1);
      begin
        wait_until(k + 78);
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
      end
    join
    repeat (3) step();
    check("pushpop_overrun", ov_seen - ov0, 0);
    drain();
    check("pushpop_n", drained.size(), 4);
    for (int i = 0; i < 4 && i < drained.size(); i++) check("pushpop_byte", drained[i], i + 2);

    // Reset during data bit 4 of 0xFF
    bus.rx = 1'b0;
    repeat (DIV) step();
    bus.rx = 1'b1;
    repeat (4 * DIV + DIV / 2) step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    fe0 = fe_seen;
    send(8'h81, 1'b1);
    drain();
    check("midrst_n", drained.size(), 1);
    if (drained.size() == 1) check("midrst_byte", drained[0], 8'h81);
    check("midrst_ferr", fe_seen - fe0, 0);

    // Randomized traffic with bursty consumer
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          bus.rx_ready = ($urandom_range(0, 255) < rdy_thresh);
          step();
        end
        bus.rx_ready = 1'b0;
      end
      begin
        for (int f = 0; f < 60; f++) begin
          rdy_thresh = ((f / 10) % 2 == 0) ? 2 : 80;
          b = $urandom_range(0, 255);
          ok = ($urandom_range(0, 9) != 0);
          send(8'(b), ok[0]);
          if (ok == 0) begin
            repeat ($urandom_range(0, 20)) step();
            bus.rx = 1'b1;
            repeat ($urandom_range(2, 6)) step();
          end else begin
            repeat ($urandom_range(0, 4)) step();
          end
        end
        rnd_on = 1'b0;
      end
    join
    bus.rx = 1'b1;
    repeat (5) step();
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
